// File: rtl/stream_pair_aligner.sv
// Pairs an early valid-only stream (A, buffered in a FIFO) with a late stream (B).
// Each B beat pops the oldest A and emits a registered, time-aligned (A,B) pair.
module stream_pair_aligner #(
  parameter int width      = 32,
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [width-1:0]      a_data,
  input  logic                  a_valid,
  input  logic [width-1:0]      b_data,
  input  logic                  b_valid,
  output logic [width-1:0]      a_out,
  output logic [width-1:0]      b_out,
  output logic                  out_valid,
  output logic [depth_log2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [depth_log2:0] full_level = {1'b1, {depth_log2{1'b0}}};

  logic [width-1:0]      mem [2**depth_log2];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  bypass;
  logic                  push;
  logic                  drop;
  logic                  starve;

  // An empty FIFO with A and B arriving together pairs them directly, never storing A.
  always_comb begin
    empty  = (level == '0);
    full   = (level == full_level);
    pop    = b_valid && !empty;
    bypass = b_valid && empty && a_valid;
    push   = a_valid && !bypass && (!full || pop);
    drop   = a_valid && full && !pop;
    starve = b_valid && empty && !a_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      a_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= pop || bypass;
      if (pop) begin
        a_out  <= mem[rd_ptr];
        b_out  <= b_data;
        rd_ptr <= rd_ptr + 1'b1;
      end else if (bypass) begin
        a_out <= a_data;
        b_out <= b_data;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      if (drop)
        overflow <= 1'b1;
      if (starve)
        underflow <= 1'b1;
    end
  end

  // Storage needs no reset; the read in the same cycle sees the old entry.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= a_data;
  end

endmodule

// File: doc/stream_pair_aligner.md
Name: stream_pair_aligner

Overview:
- Consumer-side complement of the fixed streaming delay line: instead of delaying a stream by a fixed, compile-time latency, it absorbs an unknown or variable latency between two valid-only streams.
- Stream A (early, e.g. reference sine/cosine sample) is buffered in a FIFO. Each stream B beat (late, e.g. processed ADC sample) pops the oldest A and emits a time-aligned (A,B) pair.
- Sits ahead of the lock-in multipliers so reference and signal samples pair correctly regardless of upstream pipeline depth.

Parameters:
- width, 32, bit width of both data streams
- depth_log2, 4, FIFO depth = 2**depth_log2 entries (16)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush: empties FIFO, clears sticky flags
- a_data  input  width  early-stream sample
- a_valid  input  1  a_data valid this cycle (no backpressure)
- b_data  input  width  late-stream sample
- b_valid  input  1  b_data valid this cycle (no backpressure)
- a_out  output  width  aligned A sample
- b_out  output  width  aligned B sample
- out_valid  output  1  pair valid, single-cycle pulse per pair
- level  output  depth_log2+1  current FIFO occupancy, 0..2**depth_log2
- overflow  output  1  sticky: an A sample was dropped
- underflow  output  1  sticky: a B sample arrived with no A available

Behaviour:
- Reset (async, reset_n=0): a_out=0, b_out=0, out_valid=0, level=0, overflow=0, underflow=0; read/write pointers = 0. FIFO RAM contents are don't-care.
- Streams are valid-only: every valid beat must be consumed or explicitly dropped.
- FIFO: circular buffer of A samples; pointers are depth_log2 bits and wrap naturally. Occupancy counter has depth_log2+1 bits; level = counter value.
- Push: a_valid=1 and (level<depth, or a pop occurs in the same cycle) -> write a_data, increment write pointer.
- Drop: a_valid=1, level==depth, no pop -> a_data discarded, overflow<=1, level unchanged.
- Pop: b_valid=1 and level>0 -> register a_out<=FIFO[rd_ptr], b_out<=b_data, out_valid<=1 next cycle, increment read pointer.
- Bypass pair: b_valid=1, level==0, a_valid=1 -> a_out<=a_data, b_out<=b_data, out_valid<=1 next cycle; no write, level stays 0.
- Underflow: b_valid=1, level==0, a_valid=0 -> no output, underflow<=1, b_data discarded.
- Latency: one cycle from b_valid to out_valid. a_out/b_out hold their last values when out_valid=0.
- Simultaneous push+pop with level>0: the popped value is the oldest entry, never the one being written. level unchanged. This applies at full as well (level==depth): both the push and the pop are accepted.
- clear=1 (synchronous, highest priority below reset): pointers=0, level=0, overflow=0, underflow=0, out_valid=0 next cycle. a_valid and b_valid in that cycle are ignored. a_out/b_out hold.
- Reset or clear mid-operation: in-flight entries are lost; the first A accepted afterwards pairs with the first B.
- Ordering is strictly FIFO: the nth accepted A pairs with the nth consuming B.

Test Plan:
- Reset check: hold reset_n=0 with random inputs -> all outputs 0. Release reset -> level=0, out_valid=0.
- Fixed offset: A=1,2,3 on cycles 0-2; B=0x10,0x20,0x30 on cycles 5-7 -> pairs (1,0x10),(2,0x20),(3,0x30) with out_valid on cycles 6-8. level peaks at 3, then returns to 0.
- Bypass pair: empty FIFO, a_valid=b_valid=1 with A=0xAA, B=0xBB in the same cycle -> next cycle a_out=0xAA, b_out=0xBB, out_valid=1; level stays 0.
- Overflow (depth_log2=2): push A=1..5 with no B -> level=4, overflow=1. Then 4 B beats -> pairs carry A=1..4; A=5 is absent. A 5th B beat -> underflow=1, no out_valid.
- Full push+pop and wrap: fill to 4, then 20 cycles of simultaneous A/B -> level stays 4, pairs stay in order across pointer wrap, overflow stays 0.
- Clear mid-stream: level=3, overflow=1, pulse clear -> level=0, overflow=0. Next A=7 then B=9 -> pair (7,9).
